// File: rtl/tl_phase_controller.sv
// Traffic-light phase sequencer with operator-editable phase durations.
// Drives the one-hot phase strobes and counter control, holds the three
// durations fed back to the phase counter, and reports remaining time.
module tl_phase_controller #(
  parameter int unsigned W       = 7,
  parameter int unsigned T_R_DEF = 3,
  parameter int unsigned T_Y_DEF = 4,
  parameter int unsigned T_G_DEF = 8,
  parameter int unsigned T_MIN   = 1,
  parameter int unsigned T_MAX   = 99
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_end,
  input  logic         y_end,
  input  logic         g_end,
  input  logic [W-1:0] count,
  input  logic         mode_btn,
  input  logic         sel_btn,
  input  logic         inc_btn,
  input  logic         dec_btn,
  output logic         fsm_r,
  output logic         fsm_y,
  output logic         fsm_g,
  output logic         set_mode,
  output logic         c_s,
  output logic [W-1:0] time_r,
  output logic [W-1:0] time_y,
  output logic [W-1:0] time_g,
  output logic [1:0]   edit_sel,
  output logic [W-1:0] remaining
);

  localparam logic [W-1:0] T_MIN_W = W'(T_MIN);
  localparam logic [W-1:0] T_MAX_W = W'(T_MAX);

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_SET    = 2'd3
  } state_t;

  state_t       state;
  logic [W-1:0] sel_time;
  logic [W-1:0] edited_time;
  logic [W-1:0] phase_time;
  logic         do_inc;
  logic         do_dec;

  // Simultaneous inc and dec cancel out.
  assign do_inc = inc_btn & ~dec_btn;
  assign do_dec = dec_btn & ~inc_btn;

  // Duration currently addressed by the edit selector.
  always_comb begin
    sel_time = time_g;
    case (edit_sel)
      2'd0:    sel_time = time_r;
      2'd1:    sel_time = time_y;
      default: sel_time = time_g;
    endcase
  end

  // Saturating edit of the selected duration; bounds checked before the step.
  always_comb begin
    edited_time = sel_time;
    if (do_inc && (sel_time < T_MAX_W)) begin
      edited_time = sel_time + W'(1);
    end else if (do_dec && (sel_time > T_MIN_W)) begin
      edited_time = sel_time - W'(1);
    end
  end

  // Phase sequencing, SET-mode editing and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RED;
      fsm_r    <= 1'b1;
      fsm_y    <= 1'b0;
      fsm_g    <= 1'b0;
      set_mode <= 1'b0;
      c_s      <= 1'b0;
      edit_sel <= 2'd0;
      time_r   <= W'(T_R_DEF);
      time_y   <= W'(T_Y_DEF);
      time_g   <= W'(T_G_DEF);
    end else begin
      c_s <= 1'b0;
      if ((state != ST_SET) && mode_btn) begin
        // Entering SET wins over any end pulse in the same cycle.
        state    <= ST_SET;
        set_mode <= 1'b1;
        edit_sel <= 2'd0;
        fsm_r    <= 1'b0;
        fsm_y    <= 1'b0;
        fsm_g    <= 1'b0;
      end else begin
        case (state)
          ST_RED: begin
            if (r_end) begin
              state <= ST_GREEN;
              fsm_r <= 1'b0;
              fsm_g <= 1'b1;
            end
          end
          ST_GREEN: begin
            if (g_end) begin
              state <= ST_YELLOW;
              fsm_g <= 1'b0;
              fsm_y <= 1'b1;
            end
          end
          ST_YELLOW: begin
            if (y_end) begin
              state <= ST_RED;
              fsm_y <= 1'b0;
              fsm_r <= 1'b1;
            end
          end
          ST_SET: begin
            // Edit lands on the old selection before the selector advances.
            case (edit_sel)
              2'd0:    time_r <= edited_time;
              2'd1:    time_y <= edited_time;
              2'd2:    time_g <= edited_time;
              default: ;
            endcase
            if (sel_btn) begin
              edit_sel <= (edit_sel >= 2'd2) ? 2'd0 : edit_sel + 2'd1;
            end
            if (mode_btn) begin
              state    <= ST_RED;
              set_mode <= 1'b0;
              c_s      <= 1'b1;
              fsm_r    <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Duration of the active phase; zero while editing.
  always_comb begin
    phase_time = '0;
    case (state)
      ST_RED:    phase_time = time_r;
      ST_GREEN:  phase_time = time_g;
      ST_YELLOW: phase_time = time_y;
      default:   phase_time = '0;
    endcase
  end

  // Remaining cycles for the display, clamped at zero.
  always_comb begin
    remaining = '0;
    if ((state != ST_SET) && (count <= phase_time)) begin
      remaining = phase_time - count;
    end
  end

endmodule

// File: tb/tb_tl_phase_controller.sv
// Self-checking bench for tl_phase_controller: attached counter model,
// directed tables for editing, and randomized stimulus against a model.
module tb_tl_phase_controller;

  logic       clk;
  logic       rst;
  logic       r_end, y_end, g_end;
  logic [6:0] count;
  logic       mode_btn, sel_btn, inc_btn, dec_btn;
  logic       fsm_r, fsm_y, fsm_g, set_mode, c_s;
  logic [6:0] time_r, time_y, time_g, remaining;
  logic [1:0] edit_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0=red 1=green 2=yellow 3=set; dur[0..2] = R,Y,G.
  int m_ph;
  int m_dur[3];
  int m_sel;
  bit m_cs;
  int tcnt;

  typedef struct {
    logic       m, s, i, d;
    logic [6:0] er, ey, eg;
    logic [1:0] es;
  } vec_t;

  vec_t tbl[$];

  tl_phase_controller dut (
    .clk(clk), .rst(rst),
    .r_end(r_end), .y_end(y_end), .g_end(g_end),
    .count(count),
    .mode_btn(mode_btn), .sel_btn(sel_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .fsm_r(fsm_r), .fsm_y(fsm_y), .fsm_g(fsm_g),
    .set_mode(set_mode), .c_s(c_s),
    .time_r(time_r), .time_y(time_y), .time_g(time_g),
    .edit_sel(edit_sel), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_update(bit r, bit m, bit s, bit i, bit d, bit re, bit ye, bit ge);
    if (r) begin
      m_ph = 0; m_dur[0] = 3; m_dur[1] = 4; m_dur[2] = 8; m_sel = 0; m_cs = 0;
      return;
    end
    m_cs = 0;
    if (m_ph != 3) begin
      if (m) begin m_ph = 3; m_sel = 0; end
      else if (m_ph == 0 && re) m_ph = 1;
      else if (m_ph == 1 && ge) m_ph = 2;
      else if (m_ph == 2 && ye) m_ph = 0;
    end else begin
      if (i && !d) m_dur[m_sel] = (m_dur[m_sel] + 1 > 99) ? 99 : m_dur[m_sel] + 1;
      if (d && !i) m_dur[m_sel] = (m_dur[m_sel] - 1 < 1) ? 1 : m_dur[m_sel] - 1;
      if (s) m_sel = (m_sel + 1) % 3;
      if (m) begin m_ph = 0; m_cs = 1; end
    end
  endfunction

  function automatic logic [34:0] model_vec(int cnt);
    int t;
    int rem;
    t = (m_ph == 0) ? m_dur[0] : (m_ph == 1) ? m_dur[2] : (m_ph == 2) ? m_dur[1] : 0;
    rem = (m_ph == 3 || cnt > t) ? 0 : t - cnt;
    return {m_ph == 0, m_ph == 2, m_ph == 1, m_ph == 3, m_cs, 2'(m_sel),
            7'(m_dur[0]), 7'(m_dur[1]), 7'(m_dur[2]), 7'(rem)};
  endfunction

  task automatic step(input bit r, input bit m, input bit s, input bit i, input bit d,
                      input bit re, input bit ye, input bit ge, input int cnt);
    rst = r; mode_btn = m; sel_btn = s; inc_btn = i; dec_btn = d;
    r_end = re; y_end = ye; g_end = ge; count = 7'(cnt);
    @(posedge clk);
    model_update(r, m, s, i, d, re, ye, ge);
    #1;
    check("cycle", {fsm_r, fsm_y, fsm_g, set_mode, c_s, edit_sel, time_r, time_y, time_g, remaining},
          model_vec(cnt));
  endtask

  // One cycle with the phase counter attached: end pulse when count reaches the duration.
  task automatic run_cycle(input bit m, input bit s, input bit i, input bit d);
    bit re, ye, ge, clr;
    int c;
    re = (m_ph == 0) && (tcnt == m_dur[0]);
    ge = (m_ph == 1) && (tcnt == m_dur[2]);
    ye = (m_ph == 2) && (tcnt == m_dur[1]);
    clr = (m_ph == 3) || m_cs || re || ye || ge;
    c = tcnt;
    step(1'b0, m, s, i, d, re, ye, ge, c);
    tcnt = clr ? 0 : tcnt + 1;
  endtask

  task automatic measure(input string name, input logic [2:0] pat, input int exp_len);
    int n;
    n = 0;
    while ({fsm_r, fsm_y, fsm_g} == pat && n < 300) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (exp_len >= 0) check(name, 64'(n), 64'(exp_len));
  endtask

  task automatic do_reset();
    tcnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tcnt = 0;
  endtask

  initial begin
    int n;
    int p_inc, p_dec;
    rst = 1'b1; mode_btn = 0; sel_btn = 0; inc_btn = 0; dec_btn = 0;
    r_end = 0; y_end = 0; g_end = 0; count = '0;

    // Reset values
    do_reset();
    check("reset_strobes", {fsm_r, fsm_y, fsm_g, set_mode, c_s, edit_sel}, {3'b100, 2'b00, 2'd0});
    check("reset_times", {time_r, time_y, time_g}, {7'd3, 7'd4, 7'd8});

    // Free run with the counter attached: R4, G9, Y5, R4
    measure("red_len", 3'b100, 4);
    measure("green_len", 3'b001, 9);
    measure("yellow_len", 3'b010, 5);
    measure("red_len2", 3'b100, 4);

    // mode_btn during green at count 2
    n = 0;
    while (!(fsm_g && tcnt == 2) && n < 200) begin run_cycle(0, 0, 0, 0); n++; end
    check("reach_green_cnt2", 64'(fsm_g && tcnt == 2), 64'd1);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("enter_set", {set_mode, fsm_r, fsm_y, fsm_g, edit_sel, remaining}, {1'b1, 3'b000, 2'd0, 7'd0});

    // Editing table
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 7'd4, 7'd4, 7'd8, 2'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 7'd5, 7'd4, 7'd8, 2'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 7'd6, 7'd4, 7'd8, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 7'd6, 7'd4, 7'd8, 2'd1});
    for (int k = 1; k <= 10; k++) begin
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 7'd6, (k >= 3) ? 7'd1 : 7'(4 - k), 7'd8, 2'd1});
    end
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 7'd6, 7'd1, 7'd8, 2'd2});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 7'd6, 7'd1, 7'd8, 2'd2});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 7'd6, 7'd1, 7'd9, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 7'd5, 7'd1, 7'd9, 2'd1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 7'd5, 7'd2, 7'd9, 2'd2});
    foreach (tbl[k]) begin
      run_cycle(tbl[k].m, tbl[k].s, tbl[k].i, tbl[k].d);
      check($sformatf("edit_row%0d", k), {time_r, time_y, time_g, edit_sel, set_mode},
            {tbl[k].er, tbl[k].ey, tbl[k].eg, tbl[k].es, 1'b1});
    end

    // Walk time_g up to 98, then saturate at 99
    for (int k = 0; k < 89; k++) run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("time_g_98", 64'(time_g), 64'd98);
    for (int k = 0; k < 5; k++) begin
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check("time_g_sat_max", 64'(time_g), 64'd99);
    end
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("inc_dec_cancel", 64'(time_g), 64'd99);

    // Exit with a same-cycle decrement: edit applies, c_s pulses once
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("exit_set", {c_s, set_mode, fsm_r, fsm_y, fsm_g, time_g}, {1'b1, 1'b0, 3'b100, 7'd98});
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("c_s_one_cycle", {c_s, fsm_r}, 2'b01);

    // New durations govern the run: G99, Y3, R6
    measure("red_after_set", 3'b100, -1);
    measure("green_len_new", 3'b001, 99);
    measure("yellow_len_new", 3'b010, 3);
    measure("red_len_new", 3'b100, 6);

    // mode_btn coincident with g_end: SET wins, no yellow
    n = 0;
    while (!(fsm_g && tcnt == m_dur[2]) && n < 300) begin run_cycle(0, 0, 0, 0); n++; end
    check("reach_g_end", 64'(fsm_g && tcnt == m_dur[2]), 64'd1);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("mode_vs_g_end", {set_mode, fsm_y, fsm_g, fsm_r}, 4'b1000);

    // Reset mid-SET after edits restores defaults
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("edits_before_rst", {time_r, time_y}, {7'd6, 7'd1});
    tcnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("rst_in_set", {time_r, time_y, time_g, fsm_r, set_mode, edit_sel, c_s},
          {7'd3, 7'd4, 7'd8, 1'b1, 1'b0, 2'd0, 1'b0});

    // Randomized stimulus against the model, biased segments to reach both limits
    for (int seg = 0; seg < 8; seg++) begin
      p_inc = (seg % 2 == 0) ? 60 : 10;
      p_dec = (seg % 2 == 0) ? 10 : 60;
      for (int k = 0; k < 400; k++) begin
        step($urandom_range(0, 399) == 0,
             $urandom_range(0, 29) == 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 99) < p_inc,
             $urandom_range(0, 99) < p_dec,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 127)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
